cic_dec_ctrl: RTL and testbench
===============================

# cic_dec_ctrl

Run-time controller for the CIC decimation datapath. Sequences start and stop, holds the programmable decimation ratio, and issues integrator-enable, comb-strobe and datapath-clear pulses. Discards the comb warm-up outputs and delivers results through a small valid/ready output FIFO with sticky overflow reporting. Sits between the register/config interface, the ADC sample stream and the integrator/comb datapath.

## Interface
- RATE_W, 6: width of decimation ratio (max ratio 2^RATE_W−1)
- STAGES, 3: CIC order; number of comb outputs discarded at warm-up
- DOUT_W, 16: output sample width
- FIFO_DEPTH, 4: output FIFO entries (power of two)
- FLUSH_CYC, 2: cycles dp_clr is held at start
- cic_clk in 1: clock, all logic on rising edge
- cic_rstn in 1: reset, asynchronous, active-low
- ctrl_start in 1: one-cycle start request
- ctrl_stop in 1: one-cycle stop request
- cfg_rate in RATE_W: decimation ratio, sampled on accepted start
- ovf_clr in 1: clears sticky overflow
- in_vld in 1: ADC sample valid this cycle
- comb_dout in DOUT_W: comb output, valid the cycle after comb_stb
- dp_clr out 1: synchronous clear to integrators/combs
- int_en out 1: integrator advance enable
- comb_stb out 1: comb/decimation strobe
- out_vld out 1: FIFO head valid
- out_rdy in 1: downstream accept
- out_data out DOUT_W: FIFO head
- ovf_flag out 1: sticky, sample dropped on full FIFO
- busy out 1: state ≠ IDLE
- ctrl_state out 2: current state encoding

## Operation
- States: IDLE=0, FLUSH=1, WARMUP=2, RUN=3.
- IDLE: outputs idle. ctrl_start with ctrl_stop low → latch rate, clear phase counter, warm-up counter, FIFO and ovf_flag → FLUSH.
- Rate latch: cfg_rate<2 clamps to 2. The rate is frozen until the next start.
- FLUSH: dp_clr=1 for FLUSH_CYC cycles → WARMUP.
- WARMUP/RUN: int_en=in_vld. The phase counter increments on in_vld. When in_vld arrives with phase==rate−1, comb_stb=1 and the phase wraps to 0.
- Capture pulse is comb_stb delayed one cycle. In WARMUP, captures only increment the warm-up counter. The STAGES-th capture moves the state to RUN and is discarded.
- RUN: each capture writes comb_dout to the FIFO. If the FIFO is full, the sample is dropped and ovf_flag is set. A simultaneous pop on a full FIFO frees a slot, so there is no drop.
- ctrl_stop in FLUSH or WARMUP → IDLE next cycle. ctrl_stop in RUN → IDLE. Any capture still pending from a strobe issued before the stop is discarded. FIFO contents stay readable in IDLE.
- ctrl_start outside IDLE is ignored. ctrl_start and ctrl_stop together in IDLE: ignored.
- ovf_clr clears ovf_flag. A set in the same cycle wins.
- Arithmetic: phase counter is RATE_W bits, unsigned. Warm-up counter is $clog2(STAGES+1) bits. FIFO pointers are $clog2(FIFO_DEPTH)+1 bits and wrap.

## Timing
- Reset values: dp_clr=0, int_en=0, comb_stb=0, out_vld=0, out_data=0, ovf_flag=0, busy=0, ctrl_state=IDLE. FIFO is empty and all counters are 0.
- Reset asserted mid-operation aborts immediately to the reset values. FIFO contents are lost.
- int_en is combinational from in_vld and state. comb_stb, dp_clr and out_* are registered.
- Start to first dp_clr: 1 cycle. Final comb_stb to out_vld: 2 cycles (strobe → capture → FIFO registered).
- Handshake: transfer when out_vld&&out_rdy. out_data is stable while out_vld&&!out_rdy. Push and pop in the same cycle are both allowed.
- Empty: out_vld=0, a pop is ignored. Full: a push is dropped as above.

## Structure
- Package cic_ctrl_pkg holds the state enum, state encodings and the default parameter constants.
- Sub-module cic_out_fifo holds the synchronous FIFO with push/pop, full/empty and a registered head.
- The FSM, rate latch, phase counter and warm-up counter live in cic_dec_ctrl.

## Test plan
- Reset, then start with rate=8 and continuous in_vld. Check dp_clr is high for 2 cycles. The first 3 comb_stb produce no output. The 4th produces out_vld 2 cycles after the strobe. After that, one output every 8 in_vld.
- cfg_rate=0 and cfg_rate=1 → strobes every 2 in_vld. Changing cfg_rate during RUN has no effect until the next start.
- Hold out_rdy=0 in RUN at rate=2. After 4 outputs the FIFO is full and the 5th sets ovf_flag. ovf_clr clears it. A push and pop in the same cycle on a full FIFO causes no drop.
- Gap in_vld (1 in 3 cycles) at rate=4 → the comb_stb spacing is 12 cycles and the phase holds across the gaps.
- ctrl_stop in WARMUP → IDLE with no outputs. ctrl_stop in RUN → IDLE, and buffered data still drains via out_rdy.
- Deassert cic_rstn mid-RUN → all outputs at reset values immediately and the FIFO is empty. Start and stop together in IDLE → stays IDLE.

Source files
------------

// File: rtl/cic_ctrl_pkg.sv
// Shared types and default parameters for the CIC decimation controller.
package cic_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_WARMUP = 2'd2,
        ST_RUN    = 2'd3
    } cic_state_e;

    localparam int DEF_RATE_W     = 6;
    localparam int DEF_STAGES     = 3;
    localparam int DEF_DOUT_W     = 16;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_FLUSH_CYC  = 2;

    // Integrators and the decimation phase only advance in these states.
    function automatic logic is_active(cic_state_e s);
        return (s == ST_WARMUP) || (s == ST_RUN);
    endfunction

endpackage

// File: rtl/cic_out_fifo.sv
// Small synchronous output FIFO with a registered head and valid/ready pop.
// A push into a full FIFO is dropped unless a pop frees a slot in the same cycle.
module cic_out_fifo import cic_ctrl_pkg::*; #(
    parameter int DW    = DEF_DOUT_W,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic          cic_clk,
    input  logic          cic_rstn,
    input  logic          clr_i,
    input  logic          push_i,
    input  logic [DW-1:0] din_i,
    input  logic          pop_i,
    output logic          vld_o,
    output logic [DW-1:0] dout_o,
    output logic          drop_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_q, rd_q, wr_d, rd_d;
    logic          vld_q;
    logic [DW-1:0] dout_q;
    logic          empty, full, push_ok, pop_ok, bypass;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop_ok  = pop_i && !empty;
    assign push_ok = push_i && (!full || pop_ok);
    assign drop_o  = push_i && full && !pop_ok;
    assign wr_d    = wr_q + PW'(push_ok);
    assign rd_d    = rd_q + PW'(pop_ok);
    // The new word becomes the head when everything older has been consumed.
    assign bypass  = push_ok && (rd_d[AW-1:0] == wr_q[AW-1:0]);

    assign vld_o  = vld_q;
    assign dout_o = dout_q;

    // Storage array, written on accepted pushes.
    always_ff @(posedge cic_clk) begin
        if (push_ok && !clr_i) begin
            mem[wr_q[AW-1:0]] <= din_i;
        end
    end

    // Pointers and registered head word.
    always_ff @(posedge cic_clk or negedge cic_rstn) begin
        if (!cic_rstn) begin
            wr_q   <= '0;
            rd_q   <= '0;
            vld_q  <= 1'b0;
            dout_q <= '0;
        end else if (clr_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            vld_q <= 1'b0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            vld_q <= (wr_d != rd_d);
            if (wr_d != rd_d) begin
                dout_q <= bypass ? din_i : mem[rd_d[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/cic_dec_ctrl.sv
// Run-time controller for the CIC decimator: start/stop sequencing, rate latch,
// decimation phase, comb warm-up discard and buffered result delivery.
module cic_dec_ctrl import cic_ctrl_pkg::*; #(
    parameter int RATE_W     = DEF_RATE_W,
    parameter int STAGES     = DEF_STAGES,
    parameter int DOUT_W     = DEF_DOUT_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int FLUSH_CYC  = DEF_FLUSH_CYC
) (
    input  logic              cic_clk,
    input  logic              cic_rstn,
    input  logic              ctrl_start,
    input  logic              ctrl_stop,
    input  logic [RATE_W-1:0] cfg_rate,
    input  logic              ovf_clr,
    input  logic              in_vld,
    input  logic [DOUT_W-1:0] comb_dout,
    output logic              dp_clr,
    output logic              int_en,
    output logic              comb_stb,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [DOUT_W-1:0] out_data,
    output logic              ovf_flag,
    output logic              busy,
    output logic [1:0]        ctrl_state
);
    localparam int WARM_W  = $clog2(STAGES + 1);
    localparam int FLUSH_W = $clog2(FLUSH_CYC + 1);

    cic_state_e         state_q, state_d;
    logic [RATE_W-1:0]  rate_q, rate_d;
    logic [RATE_W-1:0]  phase_q, phase_d;
    logic [WARM_W-1:0]  warm_q, warm_d;
    logic [FLUSH_W-1:0] flush_q, flush_d;
    logic               dp_clr_q, dp_clr_d;
    logic               comb_stb_q, comb_stb_d;
    logic               cap_q, cap_d;
    logic               ovf_q, ovf_d;
    logic               start_acc, push, fifo_drop;

    assign int_en     = in_vld && is_active(state_q);
    assign dp_clr     = dp_clr_q;
    assign comb_stb   = comb_stb_q;
    assign ovf_flag   = ovf_q;
    assign busy       = (state_q != ST_IDLE);
    assign ctrl_state = state_q;

    // Next-state logic: sequencing, decimation phase and warm-up counting.
    always_comb begin
        state_d    = state_q;
        rate_d     = rate_q;
        phase_d    = phase_q;
        warm_d     = warm_q;
        flush_d    = flush_q;
        dp_clr_d   = 1'b0;
        comb_stb_d = 1'b0;
        cap_d      = comb_stb_q;
        start_acc  = 1'b0;
        push       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cap_d = 1'b0;
                if (ctrl_start && !ctrl_stop) begin
                    start_acc = 1'b1;
                    state_d   = ST_FLUSH;
                    // Ratios below 2 cannot decimate; clamp to the minimum.
                    rate_d    = (cfg_rate < RATE_W'(2)) ? RATE_W'(2) : cfg_rate;
                    phase_d   = '0;
                    warm_d    = '0;
                    flush_d   = '0;
                    dp_clr_d  = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (ctrl_stop) begin
                    state_d = ST_IDLE;
                end else if (flush_q == FLUSH_W'(FLUSH_CYC - 1)) begin
                    state_d = ST_WARMUP;
                end else begin
                    flush_d  = flush_q + FLUSH_W'(1);
                    dp_clr_d = 1'b1;
                end
            end
            ST_WARMUP, ST_RUN: begin
                if (ctrl_stop) begin
                    // A capture already in flight is abandoned.
                    state_d = ST_IDLE;
                    cap_d   = 1'b0;
                end else begin
                    if (in_vld) begin
                        if (phase_q == rate_q - RATE_W'(1)) begin
                            phase_d    = '0;
                            comb_stb_d = 1'b1;
                        end else begin
                            phase_d = phase_q + RATE_W'(1);
                        end
                    end
                    if (cap_q) begin
                        if (state_q == ST_WARMUP) begin
                            warm_d = warm_q + WARM_W'(1);
                            if (warm_q == WARM_W'(STAGES - 1)) begin
                                state_d = ST_RUN;
                            end
                        end else begin
                            push = 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sticky overflow: start clears, a drop sets (winning over ovf_clr).
    always_comb begin
        ovf_d = ovf_q;
        if (start_acc) begin
            ovf_d = 1'b0;
        end else if (fifo_drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // Controller state and registered strobes.
    always_ff @(posedge cic_clk or negedge cic_rstn) begin
        if (!cic_rstn) begin
            state_q    <= ST_IDLE;
            rate_q     <= '0;
            phase_q    <= '0;
            warm_q     <= '0;
            flush_q    <= '0;
            dp_clr_q   <= 1'b0;
            comb_stb_q <= 1'b0;
            cap_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rate_q     <= rate_d;
            phase_q    <= phase_d;
            warm_q     <= warm_d;
            flush_q    <= flush_d;
            dp_clr_q   <= dp_clr_d;
            comb_stb_q <= comb_stb_d;
            cap_q      <= cap_d;
            ovf_q      <= ovf_d;
        end
    end

    cic_out_fifo #(
        .DW    (DOUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .cic_clk  (cic_clk),
        .cic_rstn (cic_rstn),
        .clr_i    (start_acc),
        .push_i   (push),
        .din_i    (comb_dout),
        .pop_i    (out_rdy),
        .vld_o    (out_vld),
        .dout_o   (out_data),
        .drop_o   (fifo_drop)
    );

endmodule

// File: tb/tb_cic_dec_ctrl.sv
// Directed bench for cic_dec_ctrl with a FIFO scoreboard of expected outputs.
module tb_cic_dec_ctrl;
    localparam int STAGES = 3;
    localparam int DEPTH  = 4;

    logic        cic_clk = 1'b0;
    logic        cic_rstn = 1'b0;
    logic        ctrl_start = 1'b0;
    logic        ctrl_stop = 1'b0;
    logic [5:0]  cfg_rate = '0;
    logic        ovf_clr = 1'b0;
    logic        in_vld = 1'b0;
    logic [15:0] comb_dout = '0;
    logic        out_rdy = 1'b0;
    logic        dp_clr, int_en, comb_stb, out_vld, ovf_flag, busy;
    logic [15:0] out_data;
    logic [1:0]  ctrl_state;

    cic_dec_ctrl dut (
        .cic_clk    (cic_clk),
        .cic_rstn   (cic_rstn),
        .ctrl_start (ctrl_start),
        .ctrl_stop  (ctrl_stop),
        .cfg_rate   (cfg_rate),
        .ovf_clr    (ovf_clr),
        .in_vld     (in_vld),
        .comb_dout  (comb_dout),
        .dp_clr     (dp_clr),
        .int_en     (int_en),
        .comb_stb   (comb_stb),
        .out_vld    (out_vld),
        .out_rdy    (out_rdy),
        .out_data   (out_data),
        .ovf_flag   (ovf_flag),
        .busy       (busy),
        .ctrl_state (ctrl_state)
    );

    always #5 cic_clk = ~cic_clk;

    int total = 0;
    int bad = 0;

    // scoreboard / model state
    logic [15:0] exp_q[$];
    int          st[$];
    bit          m_idle = 1'b1;
    bit          p1 = 1'b0, p2 = 1'b0;
    logic [15:0] d1 = '0, d2 = '0;
    bit          exp_ovf = 1'b0;
    int          cyc = 0;
    int          strobe_cnt = 0;
    int          first_vld = -1;
    int          n_pop = 0;
    int          fullpop_cnt = 0;
    logic [15:0] dval = 16'h1000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int gap(input int i);
        return (st.size() > i) ? (st[i] - st[i-1]) : -1;
    endfunction

    // One clock: update the model for the edge just taken, then check outputs.
    task automatic tick();
        bit          pre_pop, pre_start, pre_stop, pre_clr, push_now, popped, drop;
        logic [15:0] pre_data, push_data;
        logic [31:0] expv;
        pre_pop   = out_vld && out_rdy;
        pre_data  = out_data;
        pre_start = ctrl_start;
        pre_stop  = ctrl_stop;
        pre_clr   = ovf_clr;
        @(posedge cic_clk);
        #1;
        cyc++;
        push_now  = p1;
        push_data = d1;
        p1 = p2;
        d1 = d2;
        p2 = 1'b0;
        popped = 1'b0;
        drop = 1'b0;
        if (pre_pop) begin
            expv = (exp_q.size() != 0) ? {16'h0, exp_q.pop_front()} : 32'hDEAD_BEEF;
            chk("pop_data", {16'h0, pre_data}, expv);
            n_pop++;
            popped = 1'b1;
        end
        if (pre_stop && !m_idle) begin
            m_idle = 1'b1;
            push_now = 1'b0;
            p1 = 1'b0;
        end
        if (pre_start && !pre_stop && m_idle) begin
            m_idle = 1'b0;
            exp_q.delete();
            st.delete();
            strobe_cnt = 0;
            first_vld = -1;
            exp_ovf = 1'b0;
        end else begin
            if (push_now) begin
                if (exp_q.size() < DEPTH) begin
                    if (popped && exp_q.size() == DEPTH - 1) fullpop_cnt++;
                    exp_q.push_back(push_data);
                end else begin
                    drop = 1'b1;
                end
            end
            if (drop) exp_ovf = 1'b1;
            else if (pre_clr) exp_ovf = 1'b0;
        end
        if (comb_stb === 1'b1) begin
            strobe_cnt++;
            st.push_back(cyc);
            dval = dval + 16'h0101;
            comb_dout = dval;
            if (strobe_cnt > STAGES) begin
                p2 = 1'b1;
                d2 = dval;
            end
        end
        if (out_vld === 1'b1 && first_vld < 0) first_vld = cyc;
        chk("out_vld", {31'h0, out_vld}, {31'h0, exp_q.size() != 0});
        chk("ovf_flag", {31'h0, ovf_flag}, {31'h0, exp_ovf});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_strobes(input int n, input int budget);
        int k = 0;
        while (strobe_cnt < n && k < budget) begin
            tick();
            k++;
        end
        chk("strobe_reach", strobe_cnt, n);
    endtask

    task automatic start_run(input logic [5:0] rate);
        cfg_rate = rate;
        ctrl_start = 1'b1;
        tick();
        ctrl_start = 1'b0;
    endtask

    task automatic stop_run();
        ctrl_stop = 1'b1;
        tick();
        ctrl_stop = 1'b0;
        chk("stop_state", {30'h0, ctrl_state}, 0);
        chk("stop_busy", {31'h0, busy}, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_dp_clr"}, {31'h0, dp_clr}, 0);
        chk({tag, "_int_en"}, {31'h0, int_en}, 0);
        chk({tag, "_comb_stb"}, {31'h0, comb_stb}, 0);
        chk({tag, "_out_vld"}, {31'h0, out_vld}, 0);
        chk({tag, "_out_data"}, {16'h0, out_data}, 0);
        chk({tag, "_ovf"}, {31'h0, ovf_flag}, 0);
        chk({tag, "_busy"}, {31'h0, busy}, 0);
        chk({tag, "_state"}, {30'h0, ctrl_state}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        in_vld = 1'b1;
        ticks(2);
        chk_reset_vals("rst");
        cic_rstn = 1'b1;
        tick();

        // rate 8, continuous input: flush, warm-up discard, latency, spacing
        out_rdy = 1'b1;
        start_run(6'd8);
        chk("t1_dp_clr_a", {31'h0, dp_clr}, 1);
        chk("t1_state_flush", {30'h0, ctrl_state}, 1);
        tick();
        chk("t1_dp_clr_b", {31'h0, dp_clr}, 1);
        tick();
        chk("t1_dp_clr_end", {31'h0, dp_clr}, 0);
        chk("t1_state_warm", {30'h0, ctrl_state}, 2);
        chk("t1_int_en_hi", {31'h0, int_en}, 1);
        n_pop = 0;
        wait_strobes(4, 200);
        ticks(2);
        chk("t1_latency", (st.size() > 3) ? first_vld - st[3] : -1, 2);
        chk("t1_state_run", {30'h0, ctrl_state}, 3);
        wait_strobes(7, 200);
        chk("t1_gap_a", gap(4), 8);
        chk("t1_gap_b", gap(6), 8);
        ticks(4);
        chk("t1_npop", n_pop, 4);
        in_vld = 1'b0;
        #1;
        chk("t1_int_en_lo", {31'h0, int_en}, 0);
        stop_run();
        ticks(2);

        // clamped ratios; rate change during run has no effect
        in_vld = 1'b1;
        start_run(6'd0);
        wait_strobes(6, 200);
        chk("t2_gap_r0", gap(5), 2);
        cfg_rate = 6'd8;
        wait_strobes(9, 200);
        chk("t2_gap_frozen", gap(8), 2);
        stop_run();
        ticks(2);

        // rate 1 with stalled output: fill, overflow, clear, push+pop on full
        out_rdy = 1'b0;
        start_run(6'd1);
        wait_strobes(4, 200);
        chk("t3_gap_r1", gap(3), 2);
        wait_strobes(8, 200);
        in_vld = 1'b0;
        ticks(3);
        chk("t3_ovf_set", {31'h0, ovf_flag}, 1);
        chk("t3_full_vld", {31'h0, out_vld}, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("t3_ovf_clr", {31'h0, ovf_flag}, 0);
        fullpop_cnt = 0;
        in_vld = 1'b1;
        for (int i = 0; i < 20; i++) begin
            out_rdy = p1 && (exp_q.size() == DEPTH);
            tick();
        end
        chk("t3_fullpop_seen", {31'h0, fullpop_cnt != 0}, 1);
        chk("t3_no_ovf", {31'h0, ovf_flag}, 0);
        in_vld = 1'b0;
        out_rdy = 1'b1;
        ticks(8);
        chk("t3_drained", {31'h0, out_vld}, 0);
        stop_run();

        // gapped input at rate 4: one strobe per 12 cycles
        start_run(6'd4);
        for (int k = 0; k < 400 && strobe_cnt < 6; k++) begin
            in_vld = (k % 3 == 0);
            tick();
        end
        chk("t4_gap_a", gap(2), 12);
        chk("t4_gap_b", gap(5), 12);

        // stop in RUN with buffered data, then drain in IDLE
        out_rdy = 1'b0;
        in_vld = 1'b1;
        wait_strobes(8, 100);
        ticks(2);
        stop_run();
        chk("t4_buffered", {31'h0, out_vld}, 1);
        out_rdy = 1'b1;
        ticks(6);
        chk("t4_empty", {31'h0, out_vld}, 0);

        // stop during warm-up: no outputs
        start_run(6'd8);
        wait_strobes(1, 100);
        stop_run();
        ticks(20);
        chk("t5_no_stb", {31'h0, comb_stb}, 0);

        // asynchronous reset mid-run
        out_rdy = 1'b0;
        start_run(6'd2);
        wait_strobes(6, 100);
        ticks(2);
        chk("t6_pre_vld", {31'h0, out_vld}, 1);
        #3;
        cic_rstn = 1'b0;
        #1;
        chk_reset_vals("t6");
        exp_q.delete();
        p1 = 1'b0;
        p2 = 1'b0;
        m_idle = 1'b1;
        exp_ovf = 1'b0;
        #2;
        cic_rstn = 1'b1;
        tick();
        chk("t6_after_vld", {31'h0, out_vld}, 0);

        // start and stop together in IDLE are ignored
        ctrl_start = 1'b1;
        ctrl_stop = 1'b1;
        tick();
        ctrl_start = 1'b0;
        ctrl_stop = 1'b0;
        chk("t7_state", {30'h0, ctrl_state}, 0);
        chk("t7_dp_clr", {31'h0, dp_clr}, 0);
        tick();
        chk("t7_busy", {31'h0, busy}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
